pbus_master: RTL and testbench
==============================

PBUS_MASTER -- requirements
Module: pbus_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default `GlobalAddrWidth, meaning word-address width (byte address bits ADDR_W+1:2).
REQ-002 The block SHALL have parameter DATA_W, default `GlobalDataWidth (32), meaning PBus data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles to wait in any ready-wait state.
REQ-004 The block SHALL have port Clk, input, 1 bit, meaning the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit, meaning synchronous, active-high reset.
REQ-006 The block SHALL have port CmdValid, input, 1 bit, meaning a command is offered.
REQ-007 The block SHALL have port CmdReady, output, 1 bit, meaning a command is accepted this cycle.
REQ-008 The block SHALL have port CmdWrite, input, 1 bit, meaning write=1, read=0.
REQ-009 The block SHALL have port CmdAddr, input, ADDR_W bits, meaning the word address.
REQ-010 The block SHALL have port CmdData, input, DATA_W bits, meaning the write data.
REQ-011 The block SHALL have port RspValid, output, 1 bit, meaning a response is held.
REQ-012 The block SHALL have port RspReady, input, 1 bit, meaning the consumer accepts the response.
REQ-013 The block SHALL have port RspData, output, DATA_W bits, meaning the read data (0 for writes and errors).
REQ-014 The block SHALL have port RspErr, output, 1 bit, meaning the transaction timed out.
REQ-015 The block SHALL have port PBusAddr, output, ADDR_W bits, meaning the bus address [ADDR_W+1:2].
REQ-016 The block SHALL have port PBusDataOut, output, DATA_W bits, meaning write data.
REQ-017 The block SHALL have port PBusDataOE, output, 1 bit, meaning the data-bus drive enable; the tristate buffer lives at top level.
REQ-018 The block SHALL have port PBusDataIn, input, DATA_W bits, meaning read data from the bus.
REQ-019 The block SHALL have ports PBusRDN and PBusWRN, outputs, 1 bit each, meaning active-low read and write strobes.
REQ-020 The block SHALL have port PBusReadyN, input, 1 bit, meaning the asynchronous active-low completion from the responder.
REQ-021 The block SHALL have port PBusResetN, output, 1 bit, meaning the registered inverse of Reset.

Function
REQ-022 The block SHALL pass PBusReadyN through a 2-flop synchronizer (rdy_s, reset value 1) before any use.
REQ-023 The FSM SHALL have the states IDLE, SETUP, STROBE, RELEASE and RESP.
REQ-024 CmdReady SHALL equal 1 only in IDLE; when CmdValid&&CmdReady, the block SHALL register addr/data/write and move to SETUP.
REQ-025 SETUP SHALL last exactly 1 cycle: PBusAddr is driven, PBusDataOE=CmdWrite, and the strobes stay high; the next state is STROBE.
REQ-026 In STROBE the block SHALL hold PBusRDN=0 (read) or PBusWRN=0 (write) and wait for rdy_s==0; at that point it captures PBusDataIn (reads) into RspData and moves to RELEASE.
REQ-027 In STROBE, if the cycle counter reaches TIMEOUT with rdy_s still 1, the block SHALL set the err flag and move to RELEASE.
REQ-028 In RELEASE both strobes SHALL be high, and PBusAddr, PBusDataOut and PBusDataOE SHALL hold.
REQ-029 RELEASE SHALL wait for rdy_s==1, then move to RESP; if TIMEOUT cycles expire first, the block SHALL set err and move to RESP.
REQ-030 On entering RESP the block SHALL clear PBusDataOE.
REQ-031 In RESP, RspValid SHALL be 1 and RspData/RspErr SHALL be stable; on RspReady the block SHALL return to IDLE in the same edge.
REQ-032 Minimum latency, acceptance to RspValid, SHALL be 2 + synchronizer delay + responder delay cycles; RspReady tied high SHALL allow back-to-back transactions with 1 idle cycle between them.
REQ-033 The per-state cycle counter SHALL be sized clog2(TIMEOUT+1), clear on every state change, and saturate without wrapping.
REQ-034 RspData SHALL be forced to 0 when err=1 or the transaction is a write.
REQ-035 The block SHALL never assert both strobes simultaneously, and SHALL never assert a strobe while PBusDataOE disagrees with the operation.

Reset
REQ-036 When Reset=1 at a rising edge, the next state SHALL be IDLE, whatever the current state.
REQ-037 At that same edge the outputs SHALL take these values: PBusRDN=1, PBusWRN=1, PBusDataOE=0, PBusResetN=0, RspValid=0, RspErr=0, RspData=0, PBusAddr=0, PBusDataOut=0, counter=0 and rdy_s=1.
REQ-038 A reset in the middle of a transaction SHALL abandon that transaction with no response issued.

Structure
REQ-039 The state encoding and the default TIMEOUT SHALL be placed in a shared package (pbus_pkg) alongside the widths from main_define.v.
REQ-040 The synchronizer SHALL be a sub-module named pbus_sync2.

Verification
REQ-041 The bench SHALL check a read: addr 0x10, responder drops ReadyN 3 cycles after RDN falls, data 0xDEADBEEF -> RspData=0xDEADBEEF, RspErr=0, PBusRDN low from SETUP+1 until rdy_s low.
REQ-042 The bench SHALL check a write: addr 0x20, data 0x12345678 -> PBusWRN pulses low, PBusDataOut=0x12345678 with OE=1 from SETUP through RELEASE, RspData=0, RspErr=0.
REQ-043 The bench SHALL check a timeout: responder never answers, TIMEOUT=8 -> strobe released after 8 STROBE cycles, RspErr=1, RspData=0.
REQ-044 The bench SHALL check back-pressure: RspReady=0 for 5 cycles -> RspValid and RspData held stable, CmdReady=0 throughout.
REQ-045 The bench SHALL check a reset mid-STROBE: Reset asserted for 1 cycle -> next cycle strobes=1, OE=0, PBusResetN=0, RspValid=0, state IDLE.
REQ-046 The bench SHALL check back-to-back reads with RspReady=1 -> 2 correct responses and strobes never overlapping.

Source files
------------

// File: rtl/pbus_pkg.sv
// Shared widths, timeout default and FSM state encoding for the PBus master.
// The widths mirror the global data/address widths of the system build.
package pbus_pkg;

  localparam int GLOBAL_ADDR_WIDTH = 16;
  localparam int GLOBAL_DATA_WIDTH = 32;
  localparam int DEFAULT_TIMEOUT   = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE,
    ST_RESP
  } pbus_state_e;

  // Read data is only meaningful for a read that completed without timing out.
  function automatic logic rsp_data_keep(input logic err, input logic write);
    return !err && !write;
  endfunction

endpackage

// File: rtl/pbus_sync2.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable
// reset value so an idle-high input comes out of reset already deasserted.
module pbus_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pbus_master.sv
// PBus master: turns single-beat command/response transactions into PBus
// read/write strobe cycles closed by an asynchronous ready, with a timeout.
module pbus_master
  import pbus_pkg::*;
#(
  parameter int ADDR_W  = GLOBAL_ADDR_WIDTH,
  parameter int DATA_W  = GLOBAL_DATA_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic              CmdWrite,
  input  logic [ADDR_W-1:0] CmdAddr,
  input  logic [DATA_W-1:0] CmdData,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspData,
  output logic              RspErr,
  output logic [ADDR_W-1:0] PBusAddr,
  output logic [DATA_W-1:0] PBusDataOut,
  output logic              PBusDataOE,
  input  logic [DATA_W-1:0] PBusDataIn,
  output logic              PBusRDN,
  output logic              PBusWRN,
  input  logic              PBusReadyN,
  output logic              PBusResetN
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic rdy_s;

  pbus_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              write_q, write_d;
  logic              oe_q, oe_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              err_q, err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              reset_n_q;
  logic              timeout_hit;

  pbus_sync2 #(
    .RESET_VAL(1'b1)
  ) u_ready_sync (
    .clk  (Clk),
    .reset(Reset),
    .d    (PBusReadyN),
    .q    (rdy_s)
  );

  // The counter has been cleared on entry to the wait state, so reaching
  // TIMEOUT-1 here means TIMEOUT full cycles have been spent waiting.
  assign timeout_hit = (cnt_q >= CNT_LAST);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_data_d  = rsp_data_q;
    write_d     = write_q;
    oe_d        = oe_q;
    rd_n_d      = rd_n_q;
    wr_n_d      = wr_n_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (CmdValid) begin
          addr_d  = CmdAddr;
          wdata_d = CmdData;
          write_d = CmdWrite;
          oe_d    = CmdWrite;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        rd_n_d  = write_q;
        wr_n_d  = !write_q;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (!rdy_s) begin
          if (!write_q) begin
            rdata_d = PBusDataIn;
          end
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          state_d = ST_RELEASE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (rdy_s || timeout_hit) begin
          if (!rdy_s) begin
            err_d = 1'b1;
          end
          oe_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rsp_data_keep(err_d, write_q) ? rdata_q : '0;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (RspReady) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Per-state cycle count: restarts on every transition, sticks at TIMEOUT.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_data_q  <= '0;
      write_q     <= 1'b0;
      oe_q        <= 1'b0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      reset_n_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_data_q  <= rsp_data_d;
      write_q     <= write_d;
      oe_q        <= oe_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      reset_n_q   <= 1'b1;
    end
  end

  assign CmdReady    = cmd_ready_q;
  assign RspValid    = rsp_valid_q;
  assign RspData     = rsp_data_q;
  assign RspErr      = err_q;
  assign PBusAddr    = addr_q;
  assign PBusDataOut = wdata_q;
  assign PBusDataOE  = oe_q;
  assign PBusRDN     = rd_n_q;
  assign PBusWRN     = wr_n_q;
  assign PBusResetN  = reset_n_q;

endmodule

// File: tb/tb_pbus_master.sv
// Directed bench for pbus_master: read, write, timeout, back-pressure,
// mid-strobe reset and back-to-back reads against a simple PBus responder.
module tb_pbus_master;
  import pbus_pkg::*;

  localparam int ADDR_W  = GLOBAL_ADDR_WIDTH;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic              Clk;
  logic              Reset;
  logic              CmdValid;
  logic              CmdReady;
  logic              CmdWrite;
  logic [ADDR_W-1:0] CmdAddr;
  logic [DATA_W-1:0] CmdData;
  logic              RspValid;
  logic              RspReady;
  logic [DATA_W-1:0] RspData;
  logic              RspErr;
  logic [ADDR_W-1:0] PBusAddr;
  logic [DATA_W-1:0] PBusDataOut;
  logic              PBusDataOE;
  logic [DATA_W-1:0] PBusDataIn;
  logic              PBusRDN;
  logic              PBusWRN;
  logic              PBusReadyN;
  logic              PBusResetN;

  pbus_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .CmdValid   (CmdValid),
    .CmdReady   (CmdReady),
    .CmdWrite   (CmdWrite),
    .CmdAddr    (CmdAddr),
    .CmdData    (CmdData),
    .RspValid   (RspValid),
    .RspReady   (RspReady),
    .RspData    (RspData),
    .RspErr     (RspErr),
    .PBusAddr   (PBusAddr),
    .PBusDataOut(PBusDataOut),
    .PBusDataOE (PBusDataOE),
    .PBusDataIn (PBusDataIn),
    .PBusRDN    (PBusRDN),
    .PBusWRN    (PBusWRN),
    .PBusReadyN (PBusReadyN),
    .PBusResetN (PBusResetN)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Responder: pulls ReadyN low respDelay sampled cycles after a strobe
  // falls and releases it as soon as both strobes are high again.
  logic respEnable;
  int   respDelay;
  int   strobeAge;

  function automatic logic [31:0] respData(input logic [ADDR_W-1:0] a);
    if (a == 16'h0010) return 32'hDEADBEEF;
    return 32'hA5A50000 | 32'(a);
  endfunction

  initial begin
    PBusReadyN = 1'b1;
    PBusDataIn = '0;
    strobeAge  = 0;
    forever begin
      @(negedge Clk);
      PBusDataIn = respData(PBusAddr);
      if (!PBusRDN || !PBusWRN) begin
        strobeAge++;
        if (respEnable && strobeAge >= respDelay) PBusReadyN = 1'b0;
      end else begin
        strobeAge  = 0;
        PBusReadyN = 1'b1;
      end
    end
  end

  // Per-transaction observations filled by applyStimulus.
  int          latCycles, rdnLow, wrnLow, overlapCnt, oeBad, oeCycles, outBad;
  logic [15:0] setupAddr;
  logic        setupOe;
  logic [1:0]  setupStrobes;

  task automatic applyStimulus(input logic write, input logic [ADDR_W-1:0] addr,
                               input logic [31:0] data);
    int guard;
    latCycles = 0; rdnLow = 0; wrnLow = 0; overlapCnt = 0;
    oeBad = 0; oeCycles = 0; outBad = 0;
    @(negedge Clk);
    CmdWrite = write; CmdAddr = addr; CmdData = data; CmdValid = 1'b1;
    guard = 0;
    while (!CmdReady && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    checkOutput("cmd_accept", 32'(CmdReady), 32'd1);
    @(negedge Clk);
    CmdValid     = 1'b0;
    setupAddr    = 16'(PBusAddr);
    setupOe      = PBusDataOE;
    setupStrobes = {PBusRDN, PBusWRN};
    guard = 0;
    while (!RspValid && guard < 100) begin
      if (!PBusRDN) rdnLow++;
      if (!PBusWRN) wrnLow++;
      if (!PBusRDN && !PBusWRN) overlapCnt++;
      if ((!PBusRDN || !PBusWRN) && PBusDataOE != write) oeBad++;
      if (PBusDataOE) begin
        oeCycles++;
        if (PBusDataOut !== data) outBad++;
      end
      @(negedge Clk);
      latCycles++;
      guard++;
    end
    checkOutput("rsp_valid_seen", 32'(RspValid), 32'd1);
  endtask

  task automatic releaseResponse(input string tag);
    CmdValid = 1'b0;
    RspReady = 1'b1;
    @(negedge Clk);
    RspReady = 1'b0;
    checkOutput({tag, "_rsp_cleared"}, 32'(RspValid), 32'd0);
    checkOutput({tag, "_idle_ready"}, 32'(CmdReady), 32'd1);
  endtask

  logic [ADDR_W-1:0] b2bAddr [2];
  logic [31:0]       b2bRsp  [2];

  initial begin
    int rspCount, cmdIdx, gapCnt, b2bOverlap, lateRsp;
    logic acceptPending;

    Reset = 1'b1; CmdValid = 1'b0; CmdWrite = 1'b0; CmdAddr = '0; CmdData = '0;
    RspReady = 1'b0; respEnable = 1'b1; respDelay = 3;
    repeat (3) @(negedge Clk);
    checkOutput("rst_rdn", 32'(PBusRDN), 32'd1);
    checkOutput("rst_wrn", 32'(PBusWRN), 32'd1);
    checkOutput("rst_oe", 32'(PBusDataOE), 32'd0);
    checkOutput("rst_resetn", 32'(PBusResetN), 32'd0);
    checkOutput("rst_rspvalid", 32'(RspValid), 32'd0);
    checkOutput("rst_rsperr", 32'(RspErr), 32'd0);
    checkOutput("rst_rspdata", RspData, 32'd0);
    checkOutput("rst_addr", 32'(PBusAddr), 32'd0);
    checkOutput("rst_dataout", PBusDataOut, 32'd0);
    checkOutput("rst_cmdready", 32'(CmdReady), 32'd1);
    Reset = 1'b0;
    @(negedge Clk);
    checkOutput("resetn_release", 32'(PBusResetN), 32'd1);

    // Read of 0x10 with the responder answering three cycles into the strobe.
    applyStimulus(1'b0, 16'h0010, 32'h0);
    checkOutput("rd_data", RspData, 32'hDEADBEEF);
    checkOutput("rd_err", 32'(RspErr), 32'd0);
    checkOutput("rd_latency", latCycles, 32'd9);
    checkOutput("rd_rdn_low", rdnLow, 32'd5);
    checkOutput("rd_wrn_low", wrnLow, 32'd0);
    checkOutput("rd_setup_addr", 32'(setupAddr), 32'h10);
    checkOutput("rd_setup_oe", 32'(setupOe), 32'd0);
    checkOutput("rd_setup_strobes", 32'(setupStrobes), 32'd3);
    checkOutput("rd_oe_bad", oeBad, 32'd0);

    // Hold the response for five cycles while another command is offered.
    CmdWrite = 1'b1; CmdAddr = 16'h0044; CmdData = 32'h55AA55AA; CmdValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checkOutput("bp_valid", 32'(RspValid), 32'd1);
      checkOutput("bp_data", RspData, 32'hDEADBEEF);
      checkOutput("bp_cmdready", 32'(CmdReady), 32'd0);
    end
    releaseResponse("rd");

    applyStimulus(1'b1, 16'h0020, 32'h12345678);
    checkOutput("wr_data", RspData, 32'd0);
    checkOutput("wr_err", 32'(RspErr), 32'd0);
    checkOutput("wr_latency", latCycles, 32'd9);
    checkOutput("wr_wrn_low", wrnLow, 32'd5);
    checkOutput("wr_rdn_low", rdnLow, 32'd0);
    checkOutput("wr_oe_cycles", oeCycles, 32'd9);
    checkOutput("wr_out_bad", outBad, 32'd0);
    checkOutput("wr_oe_bad", oeBad, 32'd0);
    checkOutput("wr_setup_oe", 32'(setupOe), 32'd1);
    checkOutput("wr_oe_in_resp", 32'(PBusDataOE), 32'd0);
    releaseResponse("wr");

    // Silent responder: eight strobe cycles, then error response.
    respEnable = 1'b0;
    applyStimulus(1'b0, 16'h0050, 32'h0);
    checkOutput("to_err", 32'(RspErr), 32'd1);
    checkOutput("to_data", RspData, 32'd0);
    checkOutput("to_rdn_low", rdnLow, 32'd8);
    checkOutput("to_latency", latCycles, 32'd10);
    releaseResponse("to");

    // Reset while the read strobe is asserted.
    @(negedge Clk);
    CmdWrite = 1'b0; CmdAddr = 16'h0060; CmdValid = 1'b1;
    @(negedge Clk);
    CmdValid = 1'b0;
    @(negedge Clk);
    checkOutput("mid_rdn_low", 32'(PBusRDN), 32'd0);
    Reset = 1'b1;
    @(negedge Clk);
    checkOutput("mid_rdn", 32'(PBusRDN), 32'd1);
    checkOutput("mid_wrn", 32'(PBusWRN), 32'd1);
    checkOutput("mid_oe", 32'(PBusDataOE), 32'd0);
    checkOutput("mid_resetn", 32'(PBusResetN), 32'd0);
    checkOutput("mid_rspvalid", 32'(RspValid), 32'd0);
    checkOutput("mid_idle", 32'(CmdReady), 32'd1);
    Reset = 1'b0;
    respEnable = 1'b1;
    lateRsp = 0;
    repeat (12) begin
      @(negedge Clk);
      if (RspValid) lateRsp++;
    end
    checkOutput("mid_abandoned", lateRsp, 32'd0);

    // Back-to-back reads with the consumer always ready.
    b2bAddr[0] = 16'h0030;
    b2bAddr[1] = 16'h0034;
    RspReady = 1'b1;
    rspCount = 0; cmdIdx = 0; gapCnt = 0; b2bOverlap = 0; acceptPending = 1'b0;
    @(negedge Clk);
    CmdWrite = 1'b0; CmdAddr = b2bAddr[0]; CmdValid = 1'b1;
    for (int cyc = 0; cyc < 100 && rspCount < 2; cyc++) begin
      if (CmdValid && CmdReady) acceptPending = 1'b1;
      @(negedge Clk);
      if (acceptPending) begin
        acceptPending = 1'b0;
        cmdIdx++;
        if (cmdIdx < 2) CmdAddr = b2bAddr[cmdIdx];
        else CmdValid = 1'b0;
      end
      if (!PBusRDN && !PBusWRN) b2bOverlap++;
      if (rspCount == 1 && CmdReady) gapCnt++;
      if (RspValid && rspCount < 2) begin
        b2bRsp[rspCount] = RspData;
        rspCount++;
      end
    end
    RspReady = 1'b0;
    CmdValid = 1'b0;
    checkOutput("b2b_count", rspCount, 32'd2);
    checkOutput("b2b_rsp0", b2bRsp[0], 32'hA5A50030);
    checkOutput("b2b_rsp1", b2bRsp[1], 32'hA5A50034);
    checkOutput("b2b_overlap", b2bOverlap, 32'd0);
    checkOutput("b2b_gap", gapCnt, 32'd1);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
